mpmc11_fill_seq: RTL
====================

Name: mpmc11_fill_seq

Overview:
Sequences one cache-line fill for a mpmc11 port: accepts a fill request, issues one memory read command per 32-byte strip, and counts the returned read beats. For each accepted beat it drives the cache write enable and a strip-aligned cache write address. Beats arriving after the last strip, or when no fill is active, are dropped. Sits between the port request logic and the memory command interface, alongside the cache RAM write port.

Parameters:
STRIP_SHIFT, 5, log2 of bytes per strip; command and cache addresses are aligned to 2^STRIP_SHIFT.
TIMEOUT, 1023, idle cycles in WAIT_DATA before abort (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  1  fill request level; sampled only in IDLE
req_addr  in  32  fill base byte address; low STRIP_SHIFT bits ignored
req_last  in  6  index of last strip (number of strips minus 1); 0 = one strip, 63 = 64 strips
req_ack  out  1  one-cycle pulse: request accepted
busy  out  1  high in every state except IDLE
mem_cmd_en  out  1  read command valid
mem_cmd_addr  out  32  read command address, strip aligned
mem_cmd_rdy  in  1  memory accepts the command when mem_cmd_en & mem_cmd_rdy
mem_rd_valid  in  1  one read beat (one strip) returned
cache_we  out  1  cache write strobe
cache_waddr  out  32  cache write address, strip aligned
done  out  1  one-cycle pulse: fill complete
err  out  1  one-cycle pulse: fill aborted by timeout

Behaviour:
- Reset values: state IDLE; req_ack, busy, mem_cmd_en, cache_we, done, err = 0; mem_cmd_addr = 0; cache_waddr = 32'h3FFFFFFF; internal counters = 0; active = 0.
- States: IDLE, PRESET, ISSUE, WAIT_DATA. All outputs are registered.
- IDLE: if req=1, latch aligned base {req_addr[31:STRIP_SHIFT], 0} and req_last. Next cycle: state PRESET, req_ack=1 for one cycle.
- PRESET (1 cycle): mem_cmd_addr <= base; cache_waddr <= base; cmd_cnt, rd_cnt <= 0; active <= 1; mem_cmd_en <= 1; go to ISSUE.
- ISSUE: hold mem_cmd_en and mem_cmd_addr until accepted (en & rdy). On each accept: mem_cmd_addr += 2^STRIP_SHIFT and cmd_cnt++. On the accept where cmd_cnt==req_last: mem_cmd_en <= 0 in the same edge and go to WAIT_DATA.
- Beat path runs independently of state while active=1. On mem_rd_valid: cache_we=1 next cycle with cache_waddr = base + rd_cnt<<STRIP_SHIFT; rd_cnt++.
- The beat with rd_cnt==req_last clears active. It is the final write. done pulses 1 cycle later, and state returns to IDLE at that time, whether the state is ISSUE or WAIT_DATA. A done in ISSUE is impossible in legal traffic.
- A mem_rd_valid while active=0 (extra beats, stale beats after reset, beats in IDLE) is ignored: no cache_we, no counter change.
- Counter widths are 7 bits, so req_last=63 never wraps. Address arithmetic is modulo 2^32; a wrap past 32'hFFFFFFE0 wraps to 0.
- A simultaneous command accept and read beat in the same cycle are both processed.
- req while busy is ignored; no ack is given. req held high through done starts a new fill 1 cycle after returning to IDLE.
- rst asserted mid-fill aborts immediately to reset values. No done or err pulse is produced.

Optional Feature:
MPMC11_FILL_TIMEOUT_EN
- Defined: a 10+ bit watchdog counts cycles in WAIT_DATA with no mem_rd_valid and clears on each valid beat. When it reaches TIMEOUT: err pulses for 1 cycle, active <= 0, state goes to IDLE, and no done pulse is produced.
- Not defined: no watchdog; WAIT_DATA waits indefinitely and err is tied to 0.

Test Plan:
- Single strip: req_addr=0x1234_5678, req_last=0, rdy=1 → one command at 0x1234_5660; one valid → cache_we at 0x1234_5660; done 1 cycle after the write; busy low afterward.
- Backpressure: req_last=3, rdy toggling 1/0 → exactly 4 commands at base, +0x20, +0x40, +0x60; address held stable while rdy=0; 4 writes in order.
- Extra/stale beats: req_last=1, then 3 valid beats → only 2 cache_we; a valid beat in IDLE → no cache_we.
- Max length and wrap: req_addr=0xFFFF_FF00, req_last=63 → 64 commands; addresses wrap through 0x0000_0000; done after the 64th beat.
- Reset mid-fill: assert rst after 2 of 4 beats → all outputs at reset values; later valid beats ignored; new req accepted normally.
- With MPMC11_FILL_TIMEOUT_EN, TIMEOUT=16: stop valid after 1 beat → err pulse 16 cycles later, no done, state IDLE.

Source files
------------

// File: rtl/mpmc11_fill_seq.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_fill_seq
// Purpose  : Cache-line fill sequencer: one memory read command per strip,
//            counts returned beats and drives the cache RAM write port.
//            Optional watchdog abort: define MPMC11_FILL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mpmc11_fill_seq #(
    parameter int STRIP_SHIFT = 5,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic [5:0]  req_last,
    output logic        req_ack,
    output logic        busy,
    output logic        mem_cmd_en,
    output logic [31:0] mem_cmd_addr,
    input  logic        mem_cmd_rdy,
    input  logic        mem_rd_valid,
    output logic        cache_we,
    output logic [31:0] cache_waddr,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] c_STRIP_BYTES = 32'd1 << STRIP_SHIFT;
    localparam logic [31:0] c_STRIP_MASK  = c_STRIP_BYTES - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESET = 2'd1,
        S_ISSUE  = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t      r_state, w_state_d;
    logic [31:0] r_base, w_base_d;
    logic [5:0]  r_last, w_last_d;
    logic [6:0]  r_cmd_cnt, w_cmd_cnt_d;
    logic [6:0]  r_rd_cnt, w_rd_cnt_d;
    logic        r_active, w_active_d;
    logic        r_fin, w_fin_d;
    logic        r_req_ack, w_req_ack_d;
    logic        r_busy, w_busy_d;
    logic        r_cmd_en, w_cmd_en_d;
    logic [31:0] r_cmd_addr, w_cmd_addr_d;
    logic        r_cache_we, w_cache_we_d;
    logic [31:0] r_cache_waddr, w_cache_waddr_d;
    logic        r_done, w_done_d;
    logic        w_accept;
    logic        w_beat;

`ifdef MPMC11_FILL_TIMEOUT_EN
    localparam int c_WD_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT - 1);
    logic [c_WD_W-1:0] r_wd, w_wd_d;
    logic              r_err, w_err_d;
`endif

    assign w_accept = r_cmd_en & mem_cmd_rdy;
    assign w_beat   = r_active & mem_rd_valid;

    always_comb begin
        w_state_d       = r_state;
        w_base_d        = r_base;
        w_last_d        = r_last;
        w_cmd_cnt_d     = r_cmd_cnt;
        w_rd_cnt_d      = r_rd_cnt;
        w_active_d      = r_active;
        w_fin_d         = r_fin;
        w_req_ack_d     = 1'b0;
        w_cmd_en_d      = r_cmd_en;
        w_cmd_addr_d    = r_cmd_addr;
        w_cache_we_d    = 1'b0;
        w_cache_waddr_d = r_cache_waddr;
        w_done_d        = 1'b0;
`ifdef MPMC11_FILL_TIMEOUT_EN
        w_wd_d          = r_wd;
        w_err_d         = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_base_d    = req_addr & ~c_STRIP_MASK;
                    w_last_d    = req_last;
                    w_req_ack_d = 1'b1;
                    w_state_d   = S_PRESET;
                end
            end
            S_PRESET: begin
                w_cmd_addr_d    = r_base;
                w_cache_waddr_d = r_base;
                w_cmd_cnt_d     = '0;
                w_rd_cnt_d      = '0;
                w_active_d      = 1'b1;
                w_cmd_en_d      = 1'b1;
                w_state_d       = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_accept) begin
                    w_cmd_addr_d = r_cmd_addr + c_STRIP_BYTES;
                    w_cmd_cnt_d  = r_cmd_cnt + 7'd1;
                    if (r_cmd_cnt == {1'b0, r_last}) begin
                        w_cmd_en_d = 1'b0;
                        w_state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
            end
            default: w_state_d = S_IDLE;
        endcase

        // Beat path is independent of the command state; it only needs active.
        if (w_beat) begin
            w_cache_we_d    = 1'b1;
            w_cache_waddr_d = r_base + (32'(r_rd_cnt) << STRIP_SHIFT);
            w_rd_cnt_d      = r_rd_cnt + 7'd1;
            if (r_rd_cnt == {1'b0, r_last}) begin
                w_active_d = 1'b0;
                w_fin_d    = 1'b1;
            end
        end

        if (r_fin) begin
            w_fin_d    = 1'b0;
            w_done_d   = 1'b1;
            w_cmd_en_d = 1'b0;
            w_state_d  = S_IDLE;
        end

`ifdef MPMC11_FILL_TIMEOUT_EN
        if (r_state != S_WAIT || w_beat || !r_active) begin
            w_wd_d = '0;
        end else if (r_wd == c_WD_LIMIT) begin
            w_wd_d     = '0;
            w_err_d    = 1'b1;
            w_active_d = 1'b0;
            w_state_d  = S_IDLE;
        end else begin
            w_wd_d = r_wd + 1'b1;
        end
`endif

        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_last        <= '0;
            r_cmd_cnt     <= '0;
            r_rd_cnt      <= '0;
            r_active      <= 1'b0;
            r_fin         <= 1'b0;
            r_req_ack     <= 1'b0;
            r_busy        <= 1'b0;
            r_cmd_en      <= 1'b0;
            r_cmd_addr    <= '0;
            r_cache_we    <= 1'b0;
            r_cache_waddr <= 32'h3FFF_FFFF;
            r_done        <= 1'b0;
`ifdef MPMC11_FILL_TIMEOUT_EN
            r_wd          <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_d;
            r_base        <= w_base_d;
            r_last        <= w_last_d;
            r_cmd_cnt     <= w_cmd_cnt_d;
            r_rd_cnt      <= w_rd_cnt_d;
            r_active      <= w_active_d;
            r_fin         <= w_fin_d;
            r_req_ack     <= w_req_ack_d;
            r_busy        <= w_busy_d;
            r_cmd_en      <= w_cmd_en_d;
            r_cmd_addr    <= w_cmd_addr_d;
            r_cache_we    <= w_cache_we_d;
            r_cache_waddr <= w_cache_waddr_d;
            r_done        <= w_done_d;
`ifdef MPMC11_FILL_TIMEOUT_EN
            r_wd          <= w_wd_d;
            r_err         <= w_err_d;
`endif
        end
    end

    assign req_ack      = r_req_ack;
    assign busy         = r_busy;
    assign mem_cmd_en   = r_cmd_en;
    assign mem_cmd_addr = r_cmd_addr;
    assign cache_we     = r_cache_we;
    assign cache_waddr  = r_cache_waddr;
    assign done         = r_done;
`ifdef MPMC11_FILL_TIMEOUT_EN
    assign err          = r_err;
`else
    assign err          = 1'b0;
`endif

endmodule
`default_nettype wire
